// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if: request/response handshake plus the round-datapath bundle
// shared between the AES sequencer (slave) and its environment (master).
interface aes_round_sequencer_if;
   logic         in_valid, in_ready, in_decrypt;
   logic [1:0]   in_klen;
   logic [127:0] in_data;
   logic         out_valid, out_ready, out_err;
   logic [127:0] out_data;
   logic [127:0] dp_state, dp_rk, dp_next;
   logic         dp_inv, dp_final;
   logic [3:0]   dp_rk_idx;
   modport slave (
      input  in_valid, in_data, in_decrypt, in_klen, out_ready, dp_rk, dp_next,
      output in_ready, out_valid, out_data, out_err, dp_state, dp_inv, dp_final, dp_rk_idx
   );
   modport master (
      output in_valid, in_data, in_decrypt, in_klen, out_ready, dp_rk, dp_next,
      input  in_ready, out_valid, out_data, out_err, dp_state, dp_inv, dp_final, dp_rk_idx
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: control FSM and state register for an iterative one-round-per-cycle AES core.
// Round function and key schedule are external; this block only sequences them.
module aes_round_sequencer #(
   parameter int DW    = 128,
   parameter int NR128 = 10,
   parameter int NR192 = 12,
   parameter int NR256 = 14
) (
   input logic                  clk,
   input logic                  reset,
   aes_round_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} state_t;
   state_t        r_fsm;
   logic [DW-1:0] r_state;
   logic [3:0]    r_nr, r_round, r_rk_idx;
   logic          r_inv, r_final, r_ready, r_valid, r_err;
   logic [3:0]    w_nr;
   assign w_nr = bus.in_klen == 2'd0 ? 4'(NR128) : bus.in_klen == 2'd1 ? 4'(NR192) : 4'(NR256);
   // Key index and final flag are registered one step ahead so the datapath sees them in the round they apply to
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fsm    <= IDLE;
         r_state  <= '0;
         r_nr     <= 4'd0;
         r_round  <= 4'd0;
         r_rk_idx <= 4'd0;
         r_inv    <= 1'b0;
         r_final  <= 1'b0;
         r_ready  <= 1'b1;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         case (r_fsm)
            IDLE: if (bus.in_valid) begin
               r_ready <= 1'b0;
               if (bus.in_klen == 2'd3) begin
                  r_fsm   <= DONE;
                  r_valid <= 1'b1;
                  r_err   <= 1'b1;
               end else begin
                  r_fsm    <= INIT;
                  r_state  <= bus.in_data;
                  r_inv    <= bus.in_decrypt;
                  r_nr     <= w_nr;
                  r_err    <= 1'b0;
                  r_rk_idx <= bus.in_decrypt ? w_nr : 4'd0;
               end
            end
            INIT: begin
               r_fsm    <= ROUND;
               r_state  <= r_state ^ bus.dp_rk;
               r_round  <= 4'd1;
               r_rk_idx <= r_inv ? r_nr - 4'd1 : 4'd1;
               r_final  <= r_nr == 4'd1;
            end
            ROUND: begin
               r_state <= bus.dp_next;
               if (r_final) begin
                  r_fsm    <= DONE;
                  r_valid  <= 1'b1;
                  r_rk_idx <= 4'd0;
                  r_final  <= 1'b0;
               end else begin
                  r_round  <= r_round + 4'd1;
                  r_rk_idx <= r_inv ? r_nr - r_round - 4'd1 : r_round + 4'd1;
                  r_final  <= r_round + 4'd1 == r_nr;
               end
            end
            DONE: if (bus.out_ready) begin
               r_fsm   <= IDLE;
               r_valid <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end
   // An illegal request leaves the state register untouched, so its result is forced to zero here
   assign bus.out_data  = r_err ? '0 : r_state;
   assign bus.in_ready  = r_ready;
   assign bus.out_valid = r_valid;
   assign bus.out_err   = r_err;
   assign bus.dp_state  = r_state;
   assign bus.dp_inv    = r_inv;
   assign bus.dp_final  = r_final;
   assign bus.dp_rk_idx = r_rk_idx;
endmodule
